// File: rtl/axi_lite_reg_bank_pkg.sv
// Shared AXI4-Lite response codes, channel FSM encodings and byte-strobe helper
// for the configuration/status register bank.
package axi_lite_reg_bank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank_sync_vec.sv
// Vector synchroniser: STAGES flops in series with asynchronous reset.
// STAGES = 0 degenerates to a plain wire.
module sync_vec #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (STAGES == 0) begin : g_wire
    assign dout = din;
  end else begin : g_flops
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[STAGES-1];
  end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: RW control registers, synchronised RO status registers
// and a change-detect interrupt with W1C status and enable mask.
module axi_lite_reg_bank
  import axi_lite_reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int NUM_RW_REGS = 4,
  parameter int NUM_RO_REGS = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]    S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]    S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [32*NUM_RW_REGS-1:0] rw_out,
  input  logic [32*NUM_RO_REGS-1:0] ro_in,
  output logic                     irq
);

  localparam int          IDX_W    = ADDR_WIDTH - 2;
  localparam logic [31:0] STAT_IDX = 32'(NUM_RW_REGS + NUM_RO_REGS);
  localparam logic [31:0] EN_IDX   = 32'(NUM_RW_REGS + NUM_RO_REGS + 1);

  w_state_t                 w_state_q, w_state_d;
  logic                     aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]         aw_idx_q, aw_idx_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic                     awready_q, awready_d, wready_q, wready_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  r_state_t                 r_state_q, r_state_d;
  logic                     arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [31:0]              rw_q [NUM_RW_REGS];
  logic [31:0]              rw_d [NUM_RW_REGS];
  logic [NUM_RO_REGS-1:0]   irq_status_q, irq_status_d, irq_enable_q, irq_enable_d;
  logic [NUM_RO_REGS-1:0]   w1c_clear, ro_change;
  logic [32*NUM_RO_REGS-1:0] ro_sync, ro_prev_q, ro_prev_d;
  logic                     irq_q, irq_d;
  logic [31:0]              widx, ridx, wmask, rd_val;
  logic                     rd_ok;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  sync_vec #(.WIDTH(32*NUM_RO_REGS), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .din (ro_in),
    .dout(ro_sync)
  );

  // Write channel: capture AW and W independently, commit once both are held.
  always_comb begin
    w_state_d    = w_state_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    aw_idx_d     = aw_idx_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rw_d         = rw_q;
    irq_enable_d = irq_enable_q;
    w1c_clear    = '0;
    widx         = 32'(aw_idx_q);
    wmask        = strb_mask(wstrb_q);
    case (w_state_q)
      W_IDLE: begin
        if (awready_q && S_AXI_AWVALID) begin
          aw_held_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
        end
        if (wready_q && S_AXI_WVALID) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_held_q && w_held_q) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = RESP_SLVERR;
          w_state_d = W_RESP;
          for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (widx == 32'(i)) begin
              rw_d[i] = (rw_q[i] & ~wmask) | (wdata_q & wmask);
              bresp_d = RESP_OKAY;
            end
          end
          if (widx == STAT_IDX) begin
            w1c_clear = NUM_RO_REGS'(wdata_q & wmask);
            bresp_d   = RESP_OKAY;
          end
          if (widx == EN_IDX) begin
            irq_enable_d = NUM_RO_REGS'((32'(irq_enable_q) & ~wmask) | (wdata_q & wmask));
            bresp_d      = RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Read channel: decode on the AR handshake, hold RDATA/RRESP until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ridx      = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
    rd_val    = '0;
    rd_ok     = 1'b0;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (ridx == 32'(i)) begin
        rd_val = rw_q[i];
        rd_ok  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_RO_REGS; j++) begin
      if (ridx == 32'(NUM_RW_REGS + j)) begin
        rd_val = ro_sync[32*j +: 32];
        rd_ok  = 1'b1;
      end
    end
    if (ridx == STAT_IDX) begin
      rd_val = 32'(irq_status_q);
      rd_ok  = 1'b1;
    end
    if (ridx == EN_IDX) begin
      rd_val = 32'(irq_enable_q);
      rd_ok  = 1'b1;
    end
    case (r_state_q)
      R_IDLE: begin
        if (arready_q && S_AXI_ARVALID) begin
          rdata_d   = rd_val;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // A fresh change sets its status bit even when a W1C clears it on the same edge.
  always_comb begin
    ro_prev_d = ro_sync;
    ro_change = '0;
    for (int i = 0; i < NUM_RO_REGS; i++)
      ro_change[i] = |(ro_sync[32*i +: 32] ^ ro_prev_q[32*i +: 32]);
    irq_status_d = (irq_status_q & ~w1c_clear) | ro_change;
    irq_d        = |(irq_status_q & irq_enable_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      r_state_q    <= R_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      for (int i = 0; i < NUM_RW_REGS; i++) rw_q[i] <= '0;
      irq_status_q <= '0;
      irq_enable_q <= '0;
      ro_prev_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      aw_idx_q     <= aw_idx_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      r_state_q    <= r_state_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rw_q         <= rw_d;
      irq_status_q <= irq_status_d;
      irq_enable_q <= irq_enable_d;
      ro_prev_q    <= ro_prev_d;
      irq_q        <= irq_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RW_REGS; gi++) begin : g_rw_out
    assign rw_out[32*gi +: 32] = rw_q[gi];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign irq           = irq_q;

endmodule
